// File: rtl/pipeline_handshake_delay.sv
//==============================================================================
// Module      : pipeline_handshake_delay
// Description : LATENCY-stage valid/ready register pipeline with bubble
//               collapsing, synchronous flush and an occupancy counter.
//               LATENCY=0 builds a combinational pass-through.
//
// Ports       : clk        rising-edge clock
//               rst_n      asynchronous active-low reset
//               flush      synchronous clear of all in-flight beats
//               in_valid   upstream beat present
//               in_data    upstream payload (DW bits)
//               in_ready   beat accepted this cycle
//               out_valid  beat present at final stage
//               out_data   payload of final stage (DW bits)
//               out_ready  downstream accepts beat this cycle
//               occupancy  number of stages holding a valid beat (CW bits)
//
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipeline_handshake_delay #(
    parameter int LATENCY = 2,
    parameter int DW      = 32,
    parameter int CW      = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [CW-1:0] occupancy
);

    if (LATENCY == 0) begin : g_passthru

        assign out_valid = in_valid && !flush;
        assign out_data  = in_data;
        assign in_ready  = out_ready && !flush;
        assign occupancy = '0;

        // Clock and reset have no state to drive in the pass-through build.
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst_n};

    end else begin : g_pipe

        logic [LATENCY:1] r_v;
        logic [LATENCY:1] w_v_next;
        logic [DW-1:0]    r_d [1:LATENCY];
        logic [LATENCY:1] w_rdy;
        logic [CW-1:0]    r_occ;
        logic [CW-1:0]    w_occ_next;
        logic             w_accept;

        // A stage can take a beat when the downstream sink is ready or when
        // any stage from here to the output is empty (the hole will move up).
        // Written in this flat form instead of the recursive chain so the
        // ready path has no self-referencing vector bits.
        for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_rdy
            assign w_rdy[gi] = out_ready || !(&r_v[LATENCY:gi]);
        end

        assign in_ready = w_rdy[1] && !flush;
        assign w_accept = in_valid && in_ready;

        always_comb begin
            w_v_next   = r_v;
            w_occ_next = '0;
            if (flush) begin
                w_v_next = '0;
            end else begin
                if (w_rdy[1]) begin
                    w_v_next[1] = w_accept;
                end
                for (int i = 2; i <= LATENCY; i++) begin
                    if (w_rdy[i]) begin
                        w_v_next[i] = r_v[i-1];
                    end
                end
            end
            // Count from the next-state bits so occupancy lands on the same
            // edge as the valid bits it describes.
            for (int i = 1; i <= LATENCY; i++) begin
                w_occ_next = w_occ_next + CW'(w_v_next[i]);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= '0;
                r_occ <= '0;
                for (int i = 1; i <= LATENCY; i++) begin
                    r_d[i] <= '0;
                end
            end else begin
                r_v   <= w_v_next;
                r_occ <= w_occ_next;
                // Data registers only move with a real beat; empty slots keep
                // their old contents to avoid needless toggling.
                if (w_accept) begin
                    r_d[1] <= in_data;
                end
                for (int i = 2; i <= LATENCY; i++) begin
                    if (!flush && r_v[i-1] && w_rdy[i]) begin
                        r_d[i] <= r_d[i-1];
                    end
                end
            end
        end

        assign out_valid = r_v[LATENCY];
        assign out_data  = r_d[LATENCY];
        assign occupancy = r_occ;

    end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_handshake_delay.sv
//==============================================================================
// Module      : tb_pipeline_handshake_delay
// Description : Self-checking bench for pipeline_handshake_delay. Exercises a
//               LATENCY=3 build with a directed vector table and hand-written
//               reset/flush sequences, and LATENCY=3/1/0 builds with random
//               valid/ready traffic against queue scoreboards.
//
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pipeline_handshake_delay;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // LATENCY=3 instance
    logic       a_flush, a_iv, a_ir, a_ov, a_or;
    logic [7:0] a_id, a_od;
    logic [1:0] a_occ;
    // LATENCY=1 instance
    logic       b_flush, b_iv, b_ir, b_ov, b_or;
    logic [7:0] b_id, b_od;
    logic [0:0] b_occ;
    // LATENCY=0 instance
    logic       c_flush, c_iv, c_ir, c_ov, c_or;
    logic [7:0] c_id, c_od;
    logic [0:0] c_occ;

    pipeline_handshake_delay #(.LATENCY(3), .DW(8)) u_dut_l3 (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_ready(a_or), .occupancy(a_occ));

    pipeline_handshake_delay #(.LATENCY(1), .DW(8)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_ready(b_or), .occupancy(b_occ));

    pipeline_handshake_delay #(.LATENCY(0), .DW(8)) u_dut_l0 (
        .clk(clk), .rst_n(rst_n), .flush(c_flush),
        .in_valid(c_iv), .in_data(c_id), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_ready(c_or), .occupancy(c_occ));

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    //--------------------------------------------------------------------------
    // Scoreboards: a beat is pushed with its acceptance cycle when the input
    // handshake is seen and popped when the output handshake is seen.
    //--------------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] data;
        int         acc;
    } sb_t;

    sb_t a_q[$];
    sb_t b_q[$];
    sb_t c_q[$];
    logic sb_en  = 1'b0;
    logic strict = 1'b0;

    logic       a_hold_v = 1'b0, b_hold_v = 1'b0;
    logic [7:0] a_hold_d, b_hold_d;

    always @(negedge clk) begin : mon_a
        sb_t e;
        #1;
        if (sb_en) begin
            if (a_iv && a_ir) a_q.push_back({a_id, cyc});
            if (a_ov && a_or) begin
                if (a_q.size() == 0) begin
                    check("l3_unexpected_beat", {24'd0, a_od}, 32'hFFFF_FFFF);
                end else begin
                    e = a_q.pop_front();
                    check("l3_sb_data", {24'd0, a_od}, {24'd0, e.data});
                    if (strict) check("l3_latency", cyc - e.acc, 3);
                    else        check("l3_latency_min", 32'(cyc - e.acc >= 3), 1);
                end
            end
            if (a_hold_v) check("l3_data_stable", {24'd0, a_od}, {24'd0, a_hold_d});
            a_hold_v = a_ov && !a_or;
            a_hold_d = a_od;
        end else begin
            a_hold_v = 1'b0;
        end
    end

    always @(negedge clk) begin : mon_b
        sb_t e;
        #1;
        if (sb_en) begin
            if (b_iv && b_ir) b_q.push_back({b_id, cyc});
            if (b_ov && b_or) begin
                if (b_q.size() == 0) begin
                    check("l1_unexpected_beat", {24'd0, b_od}, 32'hFFFF_FFFF);
                end else begin
                    e = b_q.pop_front();
                    check("l1_sb_data", {24'd0, b_od}, {24'd0, e.data});
                    if (strict) check("l1_latency", cyc - e.acc, 1);
                    else        check("l1_latency_min", 32'(cyc - e.acc >= 1), 1);
                end
            end
            if (b_hold_v) check("l1_data_stable", {24'd0, b_od}, {24'd0, b_hold_d});
            b_hold_v = b_ov && !b_or;
            b_hold_d = b_od;
        end else begin
            b_hold_v = 1'b0;
        end
    end

    always @(negedge clk) begin : mon_c
        sb_t e;
        #1;
        if (sb_en) begin
            if (c_iv && c_ir) c_q.push_back({c_id, cyc});
            if (c_ov && c_or) begin
                if (c_q.size() == 0) begin
                    check("l0_unexpected_beat", {24'd0, c_od}, 32'hFFFF_FFFF);
                end else begin
                    e = c_q.pop_front();
                    check("l0_sb_data", {24'd0, c_od}, {24'd0, e.data});
                    check("l0_latency", cyc - e.acc, 0);
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Directed vector table for the LATENCY=3 instance. Each row gives the
    // inputs driven for one cycle and the outputs expected in that cycle,
    // before the rising edge that commits it.
    //--------------------------------------------------------------------------
    typedef struct packed {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [1:0] e_occ;
    } vec_t;

    localparam int NV = 30;
    vec_t tbl [0:NV-1];

    function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                                input logic fl, input logic e_ir, input logic e_ov,
                                input logic [7:0] e_od, input logic [1:0] e_occ);
        return '{iv:iv, id:id, ordy:ordy, fl:fl, e_ir:e_ir, e_ov:e_ov, e_od:e_od, e_occ:e_occ};
    endfunction

    task automatic drive_idle();
        a_iv = 0; a_id = 0; a_or = 0; a_flush = 0;
        b_iv = 0; b_id = 0; b_or = 0; b_flush = 0;
        c_iv = 0; c_id = 0; c_or = 0; c_flush = 0;
    endtask

    task automatic drive_random(input logic ready_high);
        a_iv = 1'($urandom_range(0, 1)); a_id = 8'($urandom);
        b_iv = 1'($urandom_range(0, 1)); b_id = 8'($urandom);
        c_iv = 1'($urandom_range(0, 1)); c_id = 8'($urandom);
        a_or = ready_high ? 1'b1 : 1'($urandom_range(0, 2) != 0);
        b_or = ready_high ? 1'b1 : 1'($urandom_range(0, 2) != 0);
        c_or = ready_high ? 1'b1 : 1'($urandom_range(0, 2) != 0);
    endtask

    initial begin
        //          iv  id     or  fl   ir  ov  od     occ
        tbl[0]  = mk(1, 8'h11, 1, 0,   1, 0, 8'h00, 0);
        tbl[1]  = mk(1, 8'h22, 1, 0,   1, 0, 8'h00, 1);
        tbl[2]  = mk(1, 8'h33, 1, 0,   1, 0, 8'h00, 2);
        tbl[3]  = mk(0, 8'h00, 1, 0,   1, 1, 8'h11, 3);
        tbl[4]  = mk(0, 8'h00, 1, 0,   1, 1, 8'h22, 2);
        tbl[5]  = mk(0, 8'h00, 1, 0,   1, 1, 8'h33, 1);
        tbl[6]  = mk(0, 8'h00, 1, 0,   1, 0, 8'h00, 0);
        tbl[7]  = mk(1, 8'hA0, 0, 0,   1, 0, 8'h00, 0);
        tbl[8]  = mk(1, 8'hA1, 0, 0,   1, 0, 8'h00, 1);
        tbl[9]  = mk(1, 8'hA2, 0, 0,   1, 0, 8'h00, 2);
        tbl[10] = mk(1, 8'hA3, 0, 0,   0, 1, 8'hA0, 3);
        tbl[11] = mk(1, 8'hA3, 0, 0,   0, 1, 8'hA0, 3);
        tbl[12] = mk(1, 8'hA3, 1, 0,   1, 1, 8'hA0, 3);
        tbl[13] = mk(1, 8'hA4, 1, 0,   1, 1, 8'hA1, 3);
        tbl[14] = mk(0, 8'h00, 1, 0,   1, 1, 8'hA2, 3);
        tbl[15] = mk(0, 8'h00, 1, 0,   1, 1, 8'hA3, 2);
        tbl[16] = mk(0, 8'h00, 1, 0,   1, 1, 8'hA4, 1);
        tbl[17] = mk(0, 8'h00, 1, 0,   1, 0, 8'h00, 0);
        tbl[18] = mk(1, 8'hB1, 1, 0,   1, 0, 8'h00, 0);
        tbl[19] = mk(1, 8'hB2, 1, 0,   1, 0, 8'h00, 1);
        tbl[20] = mk(1, 8'hB3, 1, 1,   0, 0, 8'h00, 2);
        tbl[21] = mk(0, 8'h00, 1, 0,   1, 0, 8'h00, 0);
        tbl[22] = mk(0, 8'h00, 1, 0,   1, 0, 8'h00, 0);
        tbl[23] = mk(0, 8'h00, 1, 0,   1, 0, 8'h00, 0);
        tbl[24] = mk(0, 8'h00, 1, 0,   1, 0, 8'h00, 0);
        tbl[25] = mk(1, 8'hC1, 1, 0,   1, 0, 8'h00, 0);
        tbl[26] = mk(0, 8'h00, 1, 0,   1, 0, 8'h00, 1);
        tbl[27] = mk(0, 8'h00, 1, 0,   1, 0, 8'h00, 1);
        tbl[28] = mk(0, 8'h00, 1, 1,   0, 1, 8'hC1, 1);
        tbl[29] = mk(0, 8'h00, 1, 0,   1, 0, 8'h00, 0);

        // Reset values while rst_n is held low
        rst_n = 1'b0;
        drive_idle();
        #2;
        check("rst_l3_out_valid", {31'd0, a_ov}, 0);
        check("rst_l3_occupancy", {30'd0, a_occ}, 0);
        check("rst_l3_out_data", {24'd0, a_od}, 0);
        check("rst_l3_in_ready", {31'd0, a_ir}, 1);
        check("rst_l1_in_ready", {31'd0, b_ir}, 1);
        check("rst_l1_out_valid", {31'd0, b_ov}, 0);
        a_flush = 1'b1;
        #1;
        check("rst_l3_in_ready_flush", {31'd0, a_ir}, 0);
        a_flush = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table on the LATENCY=3 instance
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_iv = tbl[i].iv; a_id = tbl[i].id; a_or = tbl[i].ordy; a_flush = tbl[i].fl;
            #1;
            check($sformatf("row%0d_in_ready", i), {31'd0, a_ir}, {31'd0, tbl[i].e_ir});
            check($sformatf("row%0d_out_valid", i), {31'd0, a_ov}, {31'd0, tbl[i].e_ov});
            check($sformatf("row%0d_occupancy", i), {30'd0, a_occ}, {30'd0, tbl[i].e_occ});
            if (tbl[i].e_ov)
                check($sformatf("row%0d_out_data", i), {24'd0, a_od}, {24'd0, tbl[i].e_od});
        end

        // Asynchronous reset mid-stream with a full, stalled pipeline
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a_iv = 1'b1; a_id = 8'hD0 + 8'(k); a_or = 1'b0; a_flush = 1'b0;
        end
        @(negedge clk);
        a_iv = 1'b0;
        #1;
        check("arst_pre_occupancy", {30'd0, a_occ}, 3);
        check("arst_pre_out_data", {24'd0, a_od}, 32'hD0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, a_ov}, 0);
        check("arst_occupancy", {30'd0, a_occ}, 0);
        check("arst_out_data", {24'd0, a_od}, 0);
        check("arst_in_ready", {31'd0, a_ir}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a_iv = 1'b1; a_id = 8'h5A; a_or = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, a_ir}, 1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            a_iv = 1'b0;
            #1;
            check($sformatf("post_rst_out_valid_c%0d", k), {31'd0, a_ov}, {31'd0, k == 3});
            if (k == 3) check("post_rst_out_data", {24'd0, a_od}, 32'h5A);
        end
        @(negedge clk);
        #1;
        check("post_rst_drained", {31'd0, a_ov}, 0);

        // LATENCY=0 combinational pass-through
        @(negedge clk);
        c_iv = 1'b1; c_id = 8'h3C; c_or = 1'b1; c_flush = 1'b0;
        #1;
        check("l0_out_valid", {31'd0, c_ov}, 1);
        check("l0_out_data", {24'd0, c_od}, 32'h3C);
        check("l0_in_ready", {31'd0, c_ir}, 1);
        check("l0_occupancy", {31'd0, c_occ}, 0);
        c_flush = 1'b1;
        #1;
        check("l0_flush_out_valid", {31'd0, c_ov}, 0);
        check("l0_flush_in_ready", {31'd0, c_ir}, 0);
        c_flush = 1'b0; c_or = 1'b0;
        #1;
        check("l0_stall_in_ready", {31'd0, c_ir}, 0);
        drive_idle();

        // Random valid/ready traffic on all three builds
        @(negedge clk);
        sb_en = 1'b1;
        drive_random(1'b0);
        repeat (400) begin
            @(negedge clk);
            drive_random(1'b0);
        end
        repeat (6) begin
            @(negedge clk);
            drive_idle();
            a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
        end
        strict = 1'b1;
        repeat (150) begin
            @(negedge clk);
            drive_random(1'b1);
        end
        repeat (6) begin
            @(negedge clk);
            drive_idle();
            a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
        end
        #2;
        check("l3_sb_empty", a_q.size(), 0);
        check("l1_sb_empty", b_q.size(), 0);
        check("l0_sb_empty", c_q.size(), 0);
        sb_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_handshake_delay.md
PIPELINE_HANDSHAKE_DELAY -- requirements
Module: pipeline_handshake_delay

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-low, port rst_n.
REQ-002 Parameter LATENCY, default 2: number of register stages between input and output, legal range 0..64.
REQ-003 Parameter DW, default 32: width of the data payload in bits, minimum 1.
REQ-004 Parameter CW, default $clog2(LATENCY+1), minimum 1: width of occupancy count.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous clear of all in-flight beats.
REQ-008 in_valid  input  1  upstream beat present.
REQ-009 in_data  input  DW  upstream payload.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 out_valid  output  1  beat present at final stage.
REQ-012 out_data  output  DW  payload of final stage.
REQ-013 out_ready  input  1  downstream accepts beat this cycle.
REQ-014 occupancy  output  CW  number of stages currently holding a valid beat.

Function
REQ-015 Stages SHALL be numbered 1..LATENCY, each holding a valid bit v[i] and a DW-bit data register d[i]; stage LATENCY drives out_valid/out_data.
REQ-016 Per-stage ready SHALL be combinational: rdy[LATENCY+1] = out_ready; rdy[i] = !v[i] || rdy[i+1] (bubble collapsing).
REQ-017 in_ready SHALL equal rdy[1] && !flush.
REQ-018 A transfer SHALL occur at input when in_valid && in_ready, at output when out_valid && out_ready, between stages i and i+1 when v[i] && rdy[i+1].
REQ-019 On each rising edge without flush, stage i (i>=2) SHALL load v[i-1]/d[i-1] when rdy[i]; stage 1 SHALL load in_valid&&in_ready / in_data when rdy[1]; a stage with rdy low SHALL hold.
REQ-020 Data registers SHALL update only when the upstream beat is valid and accepted; valid bits SHALL follow REQ-019 unconditionally.
REQ-021 With out_ready held high and no flush, a beat accepted on edge t SHALL appear on out_valid/out_data after exactly LATENCY rising edges, with sustained throughput of one beat per cycle.
REQ-022 With out_ready low, beats SHALL advance into empty stages until all stages are full; in_ready SHALL then be low until out_ready rises.
REQ-023 When all stages are full and out_ready is high, the block SHALL accept a new input beat in the same cycle the output beat leaves (no bubble).
REQ-024 Beat order SHALL be preserved; no beat SHALL be duplicated or dropped except by flush.
REQ-025 flush high on a rising edge SHALL clear all v[i] to 0; the out_valid beat presented that cycle is discarded even if out_ready is high; in_data offered that cycle is not accepted.
REQ-026 occupancy SHALL equal the population count of v[1..LATENCY], registered consistently with the valid bits (reflects state after each edge).
REQ-027 LATENCY=0 SHALL be a combinational pass-through: out_valid=in_valid&&!flush, out_data=in_data, in_ready=out_ready&&!flush, occupancy=0.
REQ-028 out_data SHALL be stable while out_valid && !out_ready (no change until accepted or flushed).

Reset
REQ-029 While rst_n is low, all v[i] SHALL be 0, all d[i] SHALL be 0, occupancy SHALL be 0, out_valid SHALL be 0, out_data SHALL be 0.
REQ-030 Reset assertion mid-operation SHALL discard all in-flight beats immediately, without waiting for a clock edge.
REQ-031 in_ready after reset SHALL equal !flush for LATENCY>=1 (all stages empty).
REQ-032 Reset deassertion SHALL be synchronised externally; the block SHALL accept a beat on the first rising edge after deassertion.

Verification
REQ-033 LATENCY=3, DW=8, out_ready=1: send 0x11,0x22,0x33 on consecutive cycles -> out_valid on cycles 3,4,5 with 0x11,0x22,0x33; occupancy peaks at 3.
REQ-034 LATENCY=3, out_ready=0, in_valid=1 with data 0xA0..0xA4 -> in_ready drops after 3 beats accepted, occupancy=3, out_data=0xA0 stable; raise out_ready -> 0xA0,0xA1,0xA2,0xA3,0xA4 exit in order, one per cycle.
REQ-035 LATENCY=3, full pipeline, out_ready=1, in_valid=1 continuous -> in_ready stays 1, no bubble, occupancy stays 3.
REQ-036 LATENCY=3, two beats in flight, assert flush one cycle -> occupancy=0, out_valid=0 next cycle, flushed beats never appear, in_ready=0 during flush cycle.
REQ-037 LATENCY=3, assert rst_n low asynchronously mid-stream -> out_valid and occupancy drop to 0 before the next edge; after release, 0x5A sent -> appears 3 cycles later.
REQ-038 LATENCY=0 and LATENCY=1 builds: random valid/ready stimulus -> scoreboard shows order preserved, exact latency 0 and 1 respectively.
